// File: rtl/mcu_pkg.sv
// Shared encodings for the 8-bit MCU front end: branch condition codes,
// sequencer states and the default program-counter width.
package mcu_pkg;

  localparam int unsigned PC_W_DEF = 8;

  typedef enum logic [2:0] {
    BR_ALW = 3'b000,
    BR_Z   = 3'b001,
    BR_NZ  = 3'b010,
    BR_C   = 3'b011,
    BR_NC  = 3'b100,
    BR_N   = 3'b101,
    BR_NN  = 3'b110,
    BR_NEV = 3'b111
  } br_cond_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO of DEPTH x PC_W entries. Pushes when full and pops
// when empty are ignored; the caller decides how to report them.
module pc_ret_stack #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0] mem [DEPTH];
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   top;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign top   = cnt - 1'b1;
  assign dout  = empty ? '0 : mem[top];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[cnt] <= din;
      cnt      <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: jumps, calls, returns, conditional
// branches, stall, halt and wrong-path squash. Optional return stack: PC_RET_STACK_EN.
module pc_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     RS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_en,
  input  logic [2:0]      br_cond,
  input  logic            flag_z,
  input  logic            flag_c,
  input  logic            flag_n,
  input  logic [PC_W-1:0] BrA,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            call_en,
  input  logic            ret_en,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            taken,
  output logic            halted,
  output logic            stk_err
);

  state_t          state;
  logic            redirect;
  logic            stk_fault;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  function automatic logic cond_true(input logic [2:0] c, input logic z,
                                     input logic cy, input logic n);
    case (br_cond_t'(c))
      BR_ALW:  return 1'b1;
      BR_Z:    return z;
      BR_NZ:   return !z;
      BR_C:    return cy;
      BR_NC:   return !cy;
      BR_N:    return n;
      BR_NN:   return !n;
      default: return 1'b0;
    endcase
  endfunction

  assign pc_inc = pc + 1'b1;

`ifdef PC_RET_STACK_EN
  logic [PC_W-1:0] rs_dout;
  logic            rs_full;
  logic            rs_empty;

  pc_ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (RS_DEPTH)
  ) u_rs (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (rs_dout),
    .full  (rs_full),
    .empty (rs_empty)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{ret_en, RS_DEPTH[0]};
  assign stk_err    = 1'b0;
`endif

  // Decode priority resolved combinationally; a failed pop falls through to pc+1.
  always_comb begin
    redirect  = 1'b0;
    target    = pc_inc;
    stk_fault = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (state == ST_RUN && !stall && !halt) begin
      if (jmp_en || call_en) begin
        redirect = 1'b1;
        target   = jmp_addr;
`ifdef PC_RET_STACK_EN
        push      = call_en;
        stk_fault = call_en && rs_full;
      end else if (ret_en) begin
        if (rs_empty) begin
          stk_fault = 1'b1;
        end else begin
          pop      = 1'b1;
          redirect = 1'b1;
          target   = rs_dout;
        end
`endif
      end else if (br_en && cond_true(br_cond, flag_z, flag_c, flag_n)) begin
        redirect = 1'b1;
        target   = BrA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pc      <= RESET_VEC;
      flush   <= 1'b0;
      taken   <= 1'b0;
      halted  <= 1'b0;
`ifdef PC_RET_STACK_EN
      stk_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          flush <= 1'b0;
          taken <= 1'b0;
          if (!stall) begin
            if (halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc <= target;
              if (redirect) begin
                flush <= 1'b1;
                taken <= 1'b1;
                state <= ST_FLUSH;
              end
            end
          end
`ifdef PC_RET_STACK_EN
          if (stk_fault) stk_err <= 1'b1;
`endif
        end
        ST_FLUSH: begin
          if (!stall) begin
            pc    <= pc_inc;
            flush <= 1'b0;
            taken <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule
